// File: rtl/svo_stream_switch.sv
// svo_stream_switch: frame-aligned two-source AXI-stream pixel switch.
// Switches only on start-of-frame, falls back to the test card on stall.
module svo_stream_switch #(
  parameter int SVO_BITS_PER_PIXEL = 24,
  parameter int TIMEOUT            = 4096
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          sel,
  input  logic                          in0_axis_tvalid,
  output logic                          in0_axis_tready,
  input  logic [SVO_BITS_PER_PIXEL-1:0] in0_axis_tdata,
  input  logic                          in0_axis_tuser,
  input  logic                          in1_axis_tvalid,
  output logic                          in1_axis_tready,
  input  logic [SVO_BITS_PER_PIXEL-1:0] in1_axis_tdata,
  input  logic                          in1_axis_tuser,
  output logic                          out_axis_tvalid,
  input  logic                          out_axis_tready,
  output logic [SVO_BITS_PER_PIXEL-1:0] out_axis_tdata,
  output logic                          out_axis_tuser,
  output logic                          cur_src,
  output logic                          locked,
  output logic                          fault
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic {
    SYNC = 1'b0,
    PASS = 1'b1
  } state_t;

  state_t                        st;
  logic                          cur;
  logic [WD_W-1:0]               wd;

  logic                          sel_eff;
  logic                          pending;
  logic                          ld;
  logic                          s_valid;
  logic                          s_sof;
  logic [SVO_BITS_PER_PIXEL-1:0] s_data;
  logic                          s_ready;
  logic                          swap;
  logic                          fire;

  assign sel_eff = sel & ~fault;
  assign pending = sel_eff != cur;
  assign ld      = ~out_axis_tvalid | out_axis_tready;

  // Mux the currently owning source onto the internal beat.
  always_comb begin
    s_valid = in0_axis_tvalid;
    s_sof   = in0_axis_tuser;
    s_data  = in0_axis_tdata;
    if (cur) begin
      s_valid = in1_axis_tvalid;
      s_sof   = in1_axis_tuser;
      s_data  = in1_axis_tdata;
    end
  end

  // Frame boundary of the owner while another source is wanted.
  assign swap = (st == PASS) & ld & s_valid & s_sof & pending;

  // Live source idle for TIMEOUT consecutive cycles.
  assign fire = cur & ~in1_axis_tvalid & (wd == WD_LAST);

  // Owner ready: drain to SOF in SYNC, hold SOF at a switch boundary.
  always_comb begin
    s_ready = 1'b0;
    unique case (st)
      SYNC: s_ready = ~s_sof;
      PASS: s_ready = ld & ~swap;
    endcase
    in0_axis_tready = cur ? 1'b1 : s_ready;
    in1_axis_tready = cur ? s_ready : 1'b1;
  end

  // Scheduler state, watchdog and registered output stage.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cur             <= 1'b0;
      st              <= SYNC;
      wd              <= '0;
      fault           <= 1'b0;
      out_axis_tvalid <= 1'b0;
      out_axis_tdata  <= '0;
      out_axis_tuser  <= 1'b0;
    end else begin
      if (!cur || in1_axis_tvalid || fire) begin
        wd <= '0;
      end else begin
        wd <= wd + 1'b1;
      end
      if (!sel) begin
        fault <= 1'b0;
      end
      if (fire) begin
        cur   <= 1'b0;
        st    <= SYNC;
        fault <= 1'b1;
        // A held beat still completes; one taken now is retired.
        if (out_axis_tready) begin
          out_axis_tvalid <= 1'b0;
        end
      end else if (st == SYNC) begin
        if (s_valid && s_sof) begin
          st <= PASS;
        end
        if (out_axis_tready) begin
          out_axis_tvalid <= 1'b0;
        end
      end else if (swap) begin
        cur             <= sel_eff;
        st              <= SYNC;
        out_axis_tvalid <= 1'b0;
      end else if (ld) begin
        out_axis_tvalid <= s_valid;
        if (s_valid) begin
          out_axis_tdata <= s_data;
          out_axis_tuser <= s_sof;
        end
      end
    end
  end

  assign cur_src = cur;
  assign locked  = (st == PASS);

endmodule

// File: tb/tb_svo_stream_switch.sv
// tb_svo_stream_switch: scoreboarded bench for the frame-aligned switch.
// Phase table for status checks, frame-level model for the stream.
module tb_svo_stream_switch;

  localparam int BPP   = 24;
  localparam int TO    = 16;
  localparam int FRAME = 8;

  logic           clk = 1'b0;
  logic           resetn;
  logic           sel;
  logic           in0_axis_tvalid;
  logic           in0_axis_tready;
  logic [BPP-1:0] in0_axis_tdata;
  logic           in0_axis_tuser;
  logic           in1_axis_tvalid;
  logic           in1_axis_tready;
  logic [BPP-1:0] in1_axis_tdata;
  logic           in1_axis_tuser;
  logic           out_axis_tvalid;
  logic           out_axis_tready;
  logic [BPP-1:0] out_axis_tdata;
  logic           out_axis_tuser;
  logic           cur_src;
  logic           locked;
  logic           fault;

  svo_stream_switch #(
    .SVO_BITS_PER_PIXEL(BPP),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .sel(sel),
    .in0_axis_tvalid(in0_axis_tvalid),
    .in0_axis_tready(in0_axis_tready),
    .in0_axis_tdata(in0_axis_tdata),
    .in0_axis_tuser(in0_axis_tuser),
    .in1_axis_tvalid(in1_axis_tvalid),
    .in1_axis_tready(in1_axis_tready),
    .in1_axis_tdata(in1_axis_tdata),
    .in1_axis_tuser(in1_axis_tuser),
    .out_axis_tvalid(out_axis_tvalid),
    .out_axis_tready(out_axis_tready),
    .out_axis_tdata(out_axis_tdata),
    .out_axis_tuser(out_axis_tuser),
    .cur_src(cur_src),
    .locked(locked),
    .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [BPP-1:0] data;
    logic           user;
  } beat_t;

  typedef struct {
    logic  sel;
    logic  gap;
    logic  rnd;
    int    n;
    logic  ecur;
    logic  elock;
    logic  efault;
    string name;
  } row_t;

  beat_t q[$];
  row_t  rows[$];

  int tests = 0;
  int fails = 0;

  int   pix [2];
  int   frm [2];
  logic gap1;
  logic rr;
  logic hs0;
  logic hs1;

  logic           bcur;
  logic           bsync;
  logic           bfault;
  int             bidle;
  logic           prev_stall;
  logic [BPP-1:0] prev_data;
  logic           prev_user;
  logic           have_last;
  logic [3:0]     last_id;
  logic           idle_seen;
  logic           first_out;

  function automatic logic [BPP-1:0] pdata(input int s, input int f,
                                           input int p);
    return {4'hA, 4'(s), 8'(f), 8'(p)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive();
    in0_axis_tvalid = 1'b1;
    in0_axis_tdata  = pdata(0, frm[0], pix[0]);
    in0_axis_tuser  = (pix[0] == 0);
    in1_axis_tvalid = ~gap1;
    in1_axis_tdata  = pdata(1, frm[1], pix[1]);
    in1_axis_tuser  = (pix[1] == 0);
  endtask

  task automatic monitor();
    logic  v [2];
    logic  u [2];
    logic  r [2];
    logic  h [2];
    logic  want;
    logic  ld;
    logic  er;
    beat_t e;
    beat_t got;
    hs0 = ((in0_axis_tvalid && in0_axis_tready) === 1'b1);
    hs1 = ((in1_axis_tvalid && in1_axis_tready) === 1'b1);
    if (!resetn) begin
      q.delete();
      bcur       = 1'b0;
      bsync      = 1'b1;
      bfault     = 1'b0;
      bidle      = 0;
      prev_stall = 1'b0;
      have_last  = 1'b0;
      idle_seen  = 1'b0;
      first_out  = 1'b1;
      return;
    end
    v[0] = in0_axis_tvalid;
    v[1] = in1_axis_tvalid;
    u[0] = in0_axis_tuser;
    u[1] = in1_axis_tuser;
    r[0] = in0_axis_tready;
    r[1] = in1_axis_tready;
    h[0] = hs0;
    h[1] = hs1;
    want = sel & ~bfault;
    ld   = ~out_axis_tvalid | out_axis_tready;

    if (prev_stall) begin
      chk("hold_valid", out_axis_tvalid, 1);
      chk("hold_data", out_axis_tdata, prev_data);
      chk("hold_user", out_axis_tuser, prev_user);
    end
    if (out_axis_tvalid !== 1'b1) idle_seen = 1'b1;
    if (out_axis_tvalid && out_axis_tready) begin
      got = {out_axis_tdata, out_axis_tuser};
      if (first_out) begin
        chk("first_sof", out_axis_tuser, 1);
        first_out = 1'b0;
      end
      if (have_last && out_axis_tdata[19:16] != last_id) begin
        chk("switch_gap", idle_seen, 1);
        chk("switch_sof", out_axis_tuser, 1);
      end
      have_last = 1'b1;
      last_id   = out_axis_tdata[19:16];
      idle_seen = 1'b0;
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL sb_extra: got beat %h expected none", got);
      end else begin
        e = q.pop_front();
        if (got !== e) begin
          fails++;
          $display("FAIL sb_beat: got %h expected %h", got, e);
        end
      end
    end
    prev_stall = out_axis_tvalid & ~out_axis_tready;
    prev_data  = out_axis_tdata;
    prev_user  = out_axis_tuser;

    for (int s = 0; s < 2; s++) begin
      if (s != int'(bcur)) er = 1'b1;
      else if (bsync) er = ~u[s];
      else er = ld & ~(v[s] & u[s] & (want != bcur));
      chk($sformatf("in%0d_ready", s), r[s], er);
    end

    if (!bsync && h[bcur]) begin
      e.data = pdata(int'(bcur), frm[bcur], pix[bcur]);
      e.user = (pix[bcur] == 0);
      q.push_back(e);
    end

    if (!sel) bfault = 1'b0;
    if (bcur && !v[1] && bidle == TO - 1) begin
      bcur   = 1'b0;
      bsync  = 1'b1;
      bfault = 1'b1;
      bidle  = 0;
    end else begin
      if (bcur && !v[1]) bidle++;
      else bidle = 0;
      if (bsync) begin
        if (v[bcur] && u[bcur]) bsync = 1'b0;
      end else if (ld && v[bcur] && u[bcur] && want != bcur) begin
        bcur  = want;
        bsync = 1'b1;
      end
    end
  endtask

  task automatic advance(input int s);
    pix[s]++;
    if (pix[s] == FRAME) begin
      pix[s] = 0;
      frm[s] = (frm[s] + 1) % 256;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (hs0) advance(0);
    if (hs1) advance(1);
    if (rr) out_axis_tready = 1'($urandom_range(0, 1));
    drive();
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      sel  = rows[i].sel;
      gap1 = rows[i].gap;
      rr   = rows[i].rnd;
      if (!rr) out_axis_tready = 1'b1;
      drive();
      repeat (rows[i].n) tick();
      chk({rows[i].name, "_cur"}, cur_src, rows[i].ecur);
      chk({rows[i].name, "_lock"}, locked, rows[i].elock);
      chk({rows[i].name, "_fault"}, fault, rows[i].efault);
    end
    rr = 1'b0;
    out_axis_tready = 1'b1;
    drive();
  endtask

  task automatic wait_lock(input string name, input logic ecur);
    int n = 0;
    while (!(locked === 1'b1 && cur_src === ecur) && n < 40) begin
      tick();
      n++;
    end
    chk(name, {locked, cur_src}, {1'b1, ecur});
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_tvalid"}, out_axis_tvalid, 0);
    chk({tag, "_tdata"}, out_axis_tdata, 0);
    chk({tag, "_tuser"}, out_axis_tuser, 0);
    chk({tag, "_cur"}, cur_src, 0);
    chk({tag, "_lock"}, locked, 0);
    chk({tag, "_fault"}, fault, 0);
  endtask

  initial begin
    int n;
    rows.push_back('{1'b0, 1'b0, 1'b0, 40, 1'b0, 1'b1, 1'b0, "src0"});
    rows.push_back('{1'b0, 1'b0, 1'b1, 80, 1'b0, 1'b1, 1'b0, "rnd0"});
    rows.push_back('{1'b1, 1'b0, 1'b0, 20, 1'b1, 1'b1, 1'b0, "src1"});
    rows.push_back('{1'b1, 1'b1, 1'b0, 15, 1'b1, 1'b1, 1'b0, "idle15"});
    rows.push_back('{1'b1, 1'b0, 1'b0, 20, 1'b1, 1'b1, 1'b0, "resume"});
    rows.push_back('{1'b1, 1'b1, 1'b0, 16, 1'b0, 1'b0, 1'b1, "idle16"});
    rows.push_back('{1'b1, 1'b0, 1'b0, 12, 1'b0, 1'b1, 1'b1, "relock0"});
    rows.push_back('{1'b1, 1'b0, 1'b0, 40, 1'b0, 1'b1, 1'b1, "fhold"});
    rows.push_back('{1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0, "sel_low"});
    rows.push_back('{1'b1, 1'b0, 1'b0, 40, 1'b1, 1'b1, 1'b0, "back1"});
    rows.push_back('{1'b1, 1'b0, 1'b1, 60, 1'b1, 1'b1, 1'b0, "rnd1"});

    pix[0] = 0;
    frm[0] = 0;
    pix[1] = 3;
    frm[1] = 0;
    gap1   = 1'b0;
    rr     = 1'b0;
    resetn = 1'b0;
    sel    = 1'b0;
    out_axis_tready = 1'b1;
    drive();
    repeat (2) tick();
    chk_reset("rst");
    resetn = 1'b1;
    drive();

    run_rows(0, 1);

    n = 0;
    while (pix[0] != 4 && n < 20) begin
      tick();
      n++;
    end
    chk("align_mid", pix[0], 4);
    sel = 1'b1;
    drive();
    wait_lock("switch1", 1'b1);

    run_rows(2, 10);

    out_axis_tready = 1'b0;
    drive();
    repeat (3) tick();
    chk("held_beat", out_axis_tvalid, 1);
    resetn = 1'b0;
    sel    = 1'b0;
    drive();
    tick();
    chk_reset("rst2");
    resetn = 1'b1;
    out_axis_tready = 1'b1;
    drive();
    wait_lock("relock_rst", 1'b0);
    repeat (30) tick();

    chk("sb_left", q.size() <= 1, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/svo_stream_switch.md
# svo_stream_switch

Frame-aligned scheduler sharing the single SVO video pipeline between two AXI-stream pixel sources: source 0 is the free-running test card, source 1 is the live stream (framebuffer or pattern generator). Sits between the sources and the video encoder, switches only at start-of-frame, and falls back to the test card when the live source stalls. Non-selected sources are drained so they remain frame-synchronous.

## Interface
- SVO_BITS_PER_PIXEL, 24: pixel data width.
- TIMEOUT, 4096: consecutive idle cycles of source 1 that trigger fallback; must be ≥ 2.
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- sel  in  1  requested source (0 = test card, 1 = live).
- in0_axis_tvalid / in0_axis_tready / in0_axis_tdata / in0_axis_tuser  in/out/in/in  1/1/BPP/1  source 0; tuser[0] = start of frame (SOF).
- in1_axis_tvalid / in1_axis_tready / in1_axis_tdata / in1_axis_tuser  in/out/in/in  1/1/BPP/1  source 1, same encoding.
- out_axis_tvalid / out_axis_tready / out_axis_tdata / out_axis_tuser  out/in/out/out  1/1/BPP/1  merged stream, registered.
- cur_src  out  1  source currently owning the output.
- locked  out  1  high in PASS.
- fault  out  1  sticky fallback flag.

## Operation
- State: cur (1 bit), st ∈ {SYNC, PASS}, output register, watchdog counter wd (clog2(TIMEOUT+1) bits), fault.
- Reset values: cur=0, st=SYNC, out_axis_tvalid=0, tdata=0, tuser=0, fault=0, wd=0.
- sel_eff = sel & ~fault. Switch pending when sel_eff != cur.
- ld = !out_axis_tvalid || out_axis_tready.
- Non-selected source: tready=1 always, beats discarded.
- SYNC: selected source tready = ~tuser; non-SOF beats discarded. When selected tvalid && tuser, st←PASS. The SOF beat is not consumed and is forwarded in PASS. Output register loads nothing; a pending valid beat stays until accepted.
- PASS, normal: selected tready = ld. On ld: out_axis_tvalid ← selected tvalid; tdata/tuser ← selected beat when valid.
- PASS, switch: if ld && selected tvalid && tuser && pending, the SOF beat is not accepted (tready=0). cur←sel_eff, st←SYNC, out_axis_tvalid←0. The old source becomes non-selected and is drained.
- Watchdog: wd←0 when cur=0 or in1_axis_tvalid=1; otherwise wd←wd+1. When cur=1, in1_axis_tvalid=0 and wd==TIMEOUT-1, it fires: cur←0, st←SYNC, fault←1, wd←0. The output register is untouched, so a held beat is still delivered. A mid-frame truncation is acceptable; the encoder resyncs on the next SOF.
- fault clears on any cycle with sel=0. With fault=1, sel=1 is ignored.
- Simultaneous events: watchdog fire wins over a switch or SOF in the same cycle. resetn low wins over everything.
- Downstream backpressure keeps a compliant source's tvalid high, so stalls never count as idle.

## Timing
- Latency: 1 cycle from accepted input beat to out_axis_tvalid.
- Throughput: 1 beat/cycle in PASS with out_axis_tready=1. Output follows AXI rules: tvalid/tdata/tuser stable while tvalid && !tready.
- Switch latency: from pending to first new-source output = wait for current source's SOF + SYNC until target SOF + 1 cycle. SYNC is left on the same edge SOF is seen; that SOF appears at the output 2 edges after it was first presented.
- Watchdog: fallback registered on the TIMEOUT-th consecutive idle cycle; cur_src=0 and fault=1 visible on the next edge.
- cur_src, locked, fault are registered and combinational-free.

## Test plan
- Reset, then src0 emits 8-pixel frames (SOF on pixel 0), sel=0, ready=1 -> locked after first SOF; output equals src0 beats delayed 1 cycle; first output beat tuser=1.
- sel 0→1 mid-frame of src0, src1 phase-offset by 3 pixels -> src0 frame completes, out_axis_tvalid=0 gap, next output beat is src1 SOF; no partial src1 frame; cur_src=1.
- Random out_axis_tready (50%) over 4 frames -> no beat lost or duplicated; data stable while stalled; in*_tready never asserted for selected source while output held.
- TIMEOUT=16, cur=1, src1 drops tvalid for 15 cycles then resumes -> no fallback. Repeat with 16 idle cycles -> fault=1, cur_src=0, locked after next src0 SOF.
- fault=1 with sel=1 held -> stays on src0. sel=0 for 1 cycle then 1 -> fault clears; switch to src1 at frame boundary.
- resetn low for 1 cycle mid-PASS with a held output beat -> all outputs at reset values next edge; resumes via SYNC on src0.
